spike_event_encoder: RTL and testbench

- Sits directly downstream of the LIF neuron array.
- Captures each neuron's one-cycle spike pulse together with that neuron's membrane state and a timestamp.
- Arbitrates round-robin among neurons and buffers the resulting events in a small FIFO.
- Presents events one at a time on a valid/ready interface, so the top level can time-multiplex them onto the 8-bit output pins instead of muxing raw states.

---
 rtl/spike_event_encoder.sv | 143 ++++++++++++++
 tb/tb_spike_event_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Spike event encoder: captures neuron spikes with state and timestamp, arbitrates
// round-robin into a small FWFT FIFO, and presents events on a valid/ready port.
module spike_event_encoder #(
  parameter int N_NEURONS  = 5,
  parameter int DATA_W     = 8,
  parameter int ID_W       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_NEURONS-1:0]          spike_in,
  input  logic [N_NEURONS*DATA_W-1:0]   state_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ID_W-1:0]               ev_id,
  output logic [DATA_W-1:0]             ev_state,
  output logic [DATA_W-1:0]             ev_time,
  output logic [7:0]                    drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + 2 * DATA_W;
  localparam int DW = $clog2(N_NEURONS + 1);

  logic [DATA_W-1:0]    r_ts;
  logic [N_NEURONS-1:0] r_pending;
  logic [DATA_W-1:0]    r_cap_state [N_NEURONS];
  logic [DATA_W-1:0]    r_cap_time  [N_NEURONS];
  logic [ID_W-1:0]      r_rr_ptr;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [EW-1:0]        r_last;
  logic [7:0]           r_drop_cnt;

  logic                 w_grant_vld;
  logic [ID_W-1:0]      w_grant_id;
  logic [N_NEURONS-1:0] w_gnt;
  logic [EW-1:0]        w_push_data;
  logic                 w_pop;
  logic [EW-1:0]        w_head;
  logic [EW-1:0]        w_out;
  logic [DW-1:0]        w_drop_num;
  logic [8:0]           w_drop_sum;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Round-robin search starting just after the last granted neuron; lowest offset wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    if (r_count < CW'(FIFO_DEPTH)) begin
      for (int k = N_NEURONS; k >= 1; k--) begin
        idx = (int'(r_rr_ptr) + k) % N_NEURONS;
        if (r_pending[idx]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    w_gnt       = '0;
    w_push_data = '0;
    w_drop_num  = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      w_gnt[i] = w_grant_vld && (w_grant_id == ID_W'(i));
      if (w_gnt[i])
        w_push_data = {ID_W'(i), r_cap_state[i], r_cap_time[i]};
      if (spike_in[i] && r_pending[i] && !w_gnt[i])
        w_drop_num = w_drop_num + DW'(1);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop_num);
  end

  // Capture stage: a new spike on a neuron being granted this edge re-arms its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts       <= '0;
      r_pending  <= '0;
      r_drop_cnt <= '0;
      r_rr_ptr   <= ID_W'(N_NEURONS - 1);
      for (int i = 0; i < N_NEURONS; i++) begin
        r_cap_state[i] <= '0;
        r_cap_time[i]  <= '0;
      end
    end else begin
      r_ts       <= r_ts + DATA_W'(1);
      r_drop_cnt <= sat8(w_drop_sum);
      if (w_grant_vld)
        r_rr_ptr <= w_grant_id;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (spike_in[i] && (!r_pending[i] || w_gnt[i])) begin
          r_pending[i]   <= 1'b1;
          r_cap_state[i] <= state_in[i*DATA_W +: DATA_W];
          r_cap_time[i]  <= r_ts;
        end else if (w_gnt[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign w_pop  = ev_valid && ev_ready;
  assign w_head = r_mem[r_rd_ptr];

  // FIFO stage: push is gated by the registered count, so a full FIFO never accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++)
        r_mem[j] <= '0;
    end else begin
      if (w_grant_vld) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= w_head;
      end
      r_count <= r_count + CW'(w_grant_vld) - CW'(w_pop);
    end
  end

  // Outputs hold the most recently consumed event while the FIFO is empty.
  assign ev_valid = (r_count != '0);
  assign w_out    = ev_valid ? w_head : r_last;
  assign ev_id    = w_out[EW-1 -: ID_W];
  assign ev_state = w_out[2*DATA_W-1 -: DATA_W];
  assign ev_time  = w_out[DATA_W-1:0];
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: latency, round-robin order, back-pressure drops,
// drop counter saturation, timestamp wrap and mid-run reset.
module tb_spike_event_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  spike_in;
  logic [39:0] state_in;
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_id;
  logic [7:0]  ev_state;
  logic [7:0]  ev_time;
  logic [7:0]  drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] tb_ts;

  typedef struct {
    logic [2:0] id;
    logic [7:0] st;
    logic [7:0] tm;
  } ev_t;
  ev_t exp_q[$];

  spike_event_encoder #(
    .N_NEURONS(5), .DATA_W(8), .ID_W(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .state_in(state_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
    .ev_state(ev_state), .ev_time(ev_time), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    tb_ts = tb_ts + 8'd1;
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    spike_in = '0;
    ev_ready = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    tb_ts = 8'd0;
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [7:0] st, input logic [7:0] tm);
    ev_t e;
    e.id = id;
    e.st = st;
    e.tm = tm;
    exp_q.push_back(e);
  endtask

  task automatic set_states(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 5; i++)
      state_in[i*8 +: 8] = base + 8'(i) * step;
  endtask

  task automatic drain(input string tag, input int budget, output int gaps);
    ev_t e;
    bit  seen;
    seen     = 0;
    gaps     = 0;
    ev_ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      if (ev_valid) begin
        e = exp_q.pop_front();
        check_val({tag, "_id"},    32'(ev_id),    32'(e.id));
        check_val({tag, "_state"}, 32'(ev_state), 32'(e.st));
        check_val({tag, "_time"},  32'(ev_time),  32'(e.tm));
        seen = 1;
      end else if (seen) begin
        gaps++;
      end
      tick();
    end
    check_val({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_val({tag, "_empty"}, 32'(ev_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         gaps;
    int         nvalid;
    logic [7:0] tA;
    logic [7:0] tF;
    rst      = 1'b0;
    spike_in = '0;
    state_in = '0;
    ev_ready = 1'b0;
    tb_ts    = 8'd0;
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_valid", 32'(ev_valid), 32'd0);
    check_val("rst_id",    32'(ev_id),    32'd0);
    check_val("rst_state", 32'(ev_state), 32'd0);
    check_val("rst_time",  32'(ev_time),  32'd0);
    check_val("rst_drop",  32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    tb_ts = 8'd0;

    // single spike on neuron 0 at timestamp 3
    repeat (3) tick();
    state_in[7:0] = 8'h40;
    spike_in      = 5'b00001;
    ev_ready      = 1'b1;
    tick();
    spike_in = '0;
    check_val("t1_lat1", 32'(ev_valid), 32'd0);
    tick();
    check_val("t1_valid", 32'(ev_valid), 32'd1);
    check_val("t1_id",    32'(ev_id),    32'd0);
    check_val("t1_state", 32'(ev_state), 32'h40);
    check_val("t1_time",  32'(ev_time),  32'd3);
    check_val("t1_drop",  32'(drop_cnt), 32'd0);
    tick();
    check_val("t1_gone",  32'(ev_valid), 32'd0);
    check_val("t1_hold",  32'(ev_state), 32'h40);

    // all five neurons at once, consumer always ready
    do_reset();
    ev_ready = 1'b1;
    set_states(8'h00, 8'h10);
    spike_in = 5'b11111;
    tA       = tb_ts;
    tick();
    spike_in = '0;
    for (int i = 0; i < 5; i++) push_exp(3'(i), 8'(i * 16), tA);
    drain("t2", 20, gaps);
    check_val("t2_gaps", 32'(gaps), 32'd0);
    check_val("t2_drop", 32'(drop_cnt), 32'd0);

    // back-pressure: fill FIFO, collide on the still-pending neuron, then drain
    do_reset();
    set_states(8'h00, 8'h10);
    spike_in = 5'b11111;
    tA       = tb_ts;
    tick();
    spike_in = '0;
    repeat (4) tick();
    check_val("t3_full_valid", 32'(ev_valid), 32'd1);
    check_val("t3_full_id",    32'(ev_id),    32'd0);
    set_states(8'h80, 8'h01);
    spike_in = 5'b11111;
    tF       = tb_ts;
    tick();
    spike_in = '0;
    check_val("t3_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) push_exp(3'(i), 8'(i * 16), tA);
    push_exp(3'd4, 8'h40, tA);
    for (int i = 0; i < 4; i++) push_exp(3'(i), 8'h80 + 8'(i), tF);
    drain("t3", 40, gaps);
    check_val("t3_gaps",  32'(gaps), 32'd0);
    check_val("t3_drop2", 32'(drop_cnt), 32'd1);

    // continuous spikes on neuron 2 with a stalled consumer
    do_reset();
    state_in = '0;
    state_in[23:16] = 8'h22;
    spike_in = 5'b00100;
    repeat (200) tick();
    check_val("t4_drop200", 32'(drop_cnt), 32'd195);
    repeat (100) tick();
    check_val("t4_drop300", 32'(drop_cnt), 32'd255);
    spike_in = '0;
    tick();
    check_val("t4_sat_hold", 32'(drop_cnt), 32'd255);
    check_val("t4_head_id",  32'(ev_id),    32'd2);

    // timestamp wrap
    do_reset();
    ev_ready = 1'b1;
    repeat (255) tick();
    state_in      = '0;
    state_in[7:0] = 8'h55;
    spike_in      = 5'b00001;
    tick();
    state_in[7:0] = 8'h66;
    tick();
    spike_in = '0;
    push_exp(3'd0, 8'h55, 8'd255);
    push_exp(3'd0, 8'h66, 8'd0);
    drain("t5", 10, gaps);
    check_val("t5_gaps", 32'(gaps), 32'd0);
    check_val("t5_drop", 32'(drop_cnt), 32'd0);

    // asynchronous reset with three queued and two pending events
    do_reset();
    set_states(8'h00, 8'h10);
    spike_in = 5'b11111;
    tick();
    spike_in = 5'b01000;
    tick();
    spike_in = '0;
    repeat (2) tick();
    check_val("t6_pre_valid", 32'(ev_valid), 32'd1);
    check_val("t6_pre_drop",  32'(drop_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_valid", 32'(ev_valid), 32'd0);
    check_val("t6_rst_drop",  32'(drop_cnt), 32'd0);
    check_val("t6_rst_id",    32'(ev_id),    32'd0);
    check_val("t6_rst_state", 32'(ev_state), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tb_ts    = 8'd0;
    ev_ready = 1'b1;
    nvalid   = 0;
    for (int c = 0; c < 12; c++) begin
      if (ev_valid) nvalid++;
      tick();
    end
    check_val("t6_no_stale", 32'(nvalid), 32'd0);
    check_val("t6_drop",     32'(drop_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
